// File: rtl/prd_reclaim_if.sv
// rtl/prd_reclaim_if.sv - commit-to-free-list reclaim bus (optional stats under PRD_RECLAIM_STAT_EN)
interface prd_reclaim_if #(
    parameter int WIDTH = 5,
    parameter int PTRW  = 3
);
    logic [1:0]       i_vld;
    logic [WIDTH-1:0] i_prd0;
    logic [WIDTH-1:0] i_prd1;
    logic             o_ready;
    logic [WIDTH-1:0] o_fl_data;
    logic             o_fl_we;
    logic [PTRW:0]    o_count;
`ifdef PRD_RECLAIM_STAT_EN
    logic [31:0]      o_released;
    logic [15:0]      o_zero_drop;
`endif

    // Commit side: drives retiring lanes, observes readiness and the drain.
    modport master (
        output i_vld, i_prd0, i_prd1,
        input  o_ready, o_fl_data, o_fl_we, o_count
`ifdef PRD_RECLAIM_STAT_EN
        , input o_released, o_zero_drop
`endif
    );

    // Reclaim block side.
    modport slave (
        input  i_vld, i_prd0, i_prd1,
        output o_ready, o_fl_data, o_fl_we, o_count
`ifdef PRD_RECLAIM_STAT_EN
        , output o_released, o_zero_drop
`endif
    );
endinterface

// File: rtl/prd_reclaim.sv
// rtl/prd_reclaim.sv - stale prd reclaim FIFO feeding the free list (optional stats: PRD_RECLAIM_STAT_EN)
module prd_reclaim #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8,
    parameter int PTRW  = 3
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    prd_reclaim_if.slave  bus
);
    localparam logic [PTRW:0] READY_MAX = (PTRW+1)'(DEPTH - 2);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]  head;
    logic [PTRW-1:0]  tail;
    logic [PTRW:0]    count;

    logic             ready;
    logic             push0;
    logic             push1;
    logic             pop;
    logic [PTRW:0]    n_push;
    logic [PTRW-1:0]  wr_idx1;

    // Two free slots guarantee a full two-lane accept, so readiness never looks at i_vld.
    assign ready   = (count <= READY_MAX);
    assign push0   = ready && bus.i_vld[0] && (bus.i_prd0 != '0);
    assign push1   = ready && bus.i_vld[1] && (bus.i_prd1 != '0);
    assign pop     = (count != '0);
    assign n_push  = (PTRW+1)'(push0) + (PTRW+1)'(push1);
    // Lane 1 lands right behind lane 0 when both push, otherwise it takes the tail slot.
    assign wr_idx1 = push0 ? tail + PTRW'(1) : tail;

    assign bus.o_ready   = ready;
    assign bus.o_fl_we   = pop;
    assign bus.o_fl_data = mem[head];
    assign bus.o_count   = count;

    // Buffer storage; contents are don't-care after reset so no reset is applied.
    always_ff @(posedge i_clk) begin
        if (push0) mem[tail]    <= bus.i_prd0;
        if (push1) mem[wr_idx1] <= bus.i_prd1;
    end

    // Pointer and occupancy tracking; the free list always absorbs a pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= tail + n_push[PTRW-1:0];
            head  <= head + PTRW'(pop);
            count <= count + n_push - (PTRW+1)'(pop);
        end
    end

`ifdef PRD_RECLAIM_STAT_EN
    logic [31:0] released;
    logic [15:0] zero_drop;
    logic [15:0] n_zero;

    assign n_zero = 16'(ready && bus.i_vld[0] && (bus.i_prd0 == '0))
                  + 16'(ready && bus.i_vld[1] && (bus.i_prd1 == '0));

    assign bus.o_released  = released;
    assign bus.o_zero_drop = zero_drop;

    // Wrapping statistics: free list writes and filtered register-0 lanes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            released  <= '0;
            zero_drop <= '0;
        end else begin
            released  <= released + 32'(pop);
            zero_drop <= zero_drop + n_zero;
        end
    end
`endif
endmodule
